// File: rtl/mem_access_ctrl_pkg.sv
// mem_arb_pkg
// Shared types and constants for the data-memory access controller:
// controller state encoding, memory-owner codes and the wait-counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } stateT;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // Wide enough for LAT-1 with LAT up to 15.
    localparam int LAT_W = 4;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Bundles the three sides of the data-memory controller:
//   cpu_*  : MEM-stage load/store request, load data and pipeline stall
//   dma_*  : DMA/peripheral request, grant/done pulses and read data
//   mem_*  : single-port data memory macro
// slave  : the controller's view
// master : the view of the requesters and memory around it
interface mem_access_ctrl_if;

    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;

    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_done;
    logic [31:0] dma_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_done, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_done, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_access_ctrl_starve_cnt.sv
// mem_arb_starve_cnt
// Counts consecutive cycles the DMA has been refused the memory, saturating
// at STARVE_MAX. atMax lets the DMA override the CPU's default priority.
// Ports: clk, reset (async, active-high), inc, clr (clr wins), atMax.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic atMax
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign atMax = (cnt == MAX_V);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequences the single-port data memory behind EX/MEM, arbitrates it between
// the MEM-stage CPU port and a DMA requester, and stalls the pipeline while a
// CPU access is in progress.
// Ports: clk, reset (async, active-high), bus (mem_access_ctrl_if.slave)
// carrying the CPU, DMA and memory-macro signals.
//
//   state | meaning
//   IDLE  | no access; arbitrate and latch the winner's request
//   ISSUE | mem_en pulse; dma_gnt when the DMA owns the access
//   WAIT  | read latency countdown; capture mem_rdata at zero
//   DONE  | access complete; dma_done or CPU stall release
module mem_access_ctrl
    import mem_arb_pkg::*;
#(
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              reset,
    mem_access_ctrl_if.slave bus
);

    stateT            state, stateNext;
    logic             owner;
    logic             weQ;
    logic [31:0]      addrQ, wdataQ;
    logic [31:0]      cpuRdataQ, dmaRdataQ;
    logic [LAT_W-1:0] waitCnt;

    logic cpuReq, anyReq, pickDma, dmaOwns, atMax;
    logic starveInc, starveClr;

    assign cpuReq  = bus.cpu_rd | bus.cpu_wr;
    assign anyReq  = cpuReq | bus.dma_req;
    assign pickDma = bus.dma_req & (~cpuReq | atMax);
    assign dmaOwns = (state != IDLE) && (owner == OWN_DMA);

    assign starveInc = bus.dma_req & ~dmaOwns;
    assign starveClr = (state == IDLE) && pickDma;

    mem_arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) uStarve (
        .clk   (clk),
        .reset (reset),
        .inc   (starveInc),
        .clr   (starveClr),
        .atMax (atMax)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= OWN_CPU;
            weQ       <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            waitCnt   <= '0;
            cpuRdataQ <= '0;
            dmaRdataQ <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        if (pickDma) begin
                            owner  <= OWN_DMA;
                            weQ    <= bus.dma_we;
                            addrQ  <= bus.dma_addr;
                            wdataQ <= bus.dma_wdata;
                        end else begin
                            // rd and wr together behave as a store
                            owner  <= OWN_CPU;
                            weQ    <= bus.cpu_wr;
                            addrQ  <= bus.cpu_addr;
                            wdataQ <= bus.cpu_wdata;
                        end
                    end
                end
                ISSUE: begin
                    waitCnt <= LAT_W'(LAT - 1);
                end
                WAIT: begin
                    if (waitCnt == '0) begin
                        if (owner == OWN_DMA) begin
                            dmaRdataQ <= bus.mem_rdata;
                        end else begin
                            cpuRdataQ <= bus.mem_rdata;
                        end
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext    = state;
        bus.mem_en   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.dma_gnt  = 1'b0;
        bus.dma_done = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_en  = 1'b1;
                bus.mem_we  = weQ;
                bus.dma_gnt = (owner == OWN_DMA);
                stateNext   = weQ ? DONE : WAIT;
            end
            WAIT: begin
                if (waitCnt == '0) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                bus.dma_done = (owner == OWN_DMA);
                stateNext    = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // A requester that dropped its request mid-access still gets its access
    // finished; only a pending CPU request holds the pipeline.
    assign bus.stall = ~reset & cpuReq & ~((state == DONE) && (owner == OWN_CPU));

    assign bus.mem_addr  = addrQ;
    assign bus.mem_wdata = wdataQ;
    assign bus.cpu_rdata = cpuRdataQ;
    assign bus.dma_rdata = dmaRdataQ;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Directed and randomised traffic on the CPU and DMA ports of
// mem_access_ctrl, with a data-memory model behind it and a reference memory
// map plus latency/arbitration arithmetic predicting every result.
module tb_mem_access_ctrl;

    localparam int LAT        = 3;
    localparam int STARVE_MAX = 4;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Contents of never-written words.
    function automatic logic [31:0] initVal(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // Data memory macro: read data appears LAT cycles after the mem_en cycle,
    // garbage otherwise.
    logic [31:0] memArr [256];
    bit          memVal [256];
    logic [31:0] rdPipe [LAT];

    function automatic logic [31:0] memRead(input logic [31:0] a);
        return memVal[a[9:2]] ? memArr[a[9:2]] : initVal(a);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            memArr[bus.mem_addr[9:2]] <= bus.mem_wdata;
            memVal[bus.mem_addr[9:2]] <= 1'b1;
        end
        rdPipe[0] <= (bus.mem_en && !bus.mem_we) ? memRead(bus.mem_addr) : 32'hBAD0_BAD0;
        for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end

    assign bus.mem_rdata = rdPipe[LAT-1];

    // Reference memory map: what each address should read back.
    logic [31:0] refMem [logic [31:0]];

    function automatic logic [31:0] refRead(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : initVal(a);
    endfunction

    // DMA held off by back-to-back CPU accesses of `period` cycles each:
    // arbitration happens at multiples of period, and by then the DMA has
    // been refused that many cycles; it wins once that reaches STARVE_MAX.
    // The grant appears in the cycle after that arbitration.
    function automatic int expGnt(input int period);
        int t = 0;
        while (t < STARVE_MAX) t += period;
        return t + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setIdle();
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.dma_req   = 1'b0;
        bus.dma_we    = 1'b0;
        bus.dma_addr  = '0;
        bus.dma_wdata = '0;
    endtask

    // Results of the last runOps, cycles counted from its first request.
    int rCpuDone [4];
    int rGnt, rDmaDone, rEns, rWes, rEnFirst;

    // nCpu CPU accesses at cpuBase, +4, +8 (each presented the cycle after
    // the previous completes) alongside at most one DMA access.
    task automatic runOps(input int nCpu, input bit cpuWr, input logic [31:0] cpuBase,
                          input logic [31:0] wd0, input bit dmaOn, input bit dmaWe,
                          input logic [31:0] dmaA, input logic [31:0] dmaD);
        int          left = nCpu;
        int          k = 0;
        int          c = 0;
        bit          cpuAct = 1'b0;
        bit          dmaAct = dmaOn;
        logic [31:0] ca = '0, cd = '0, cExp = '0, dExp = '0;
        for (int i = 0; i < 4; i++) rCpuDone[i] = -1;
        rGnt = -1; rDmaDone = -1; rEns = 0; rWes = 0; rEnFirst = -1;
        if (dmaOn) begin
            dExp = refRead(dmaA);
            if (dmaWe) refMem[dmaA] = dmaD;
        end
        while ((left > 0 || cpuAct || dmaAct) && c < 200) begin
            @(negedge clk);
            if (!cpuAct && left > 0) begin
                ca   = cpuBase + 32'(4 * (nCpu - left));
                cd   = (left == nCpu) ? wd0 : $urandom;
                cExp = refRead(ca);
                if (cpuWr) refMem[ca] = cd;
                cpuAct = 1'b1;
                left--;
            end
            bus.cpu_rd    = cpuAct & ~cpuWr;
            bus.cpu_wr    = cpuAct & cpuWr;
            bus.cpu_addr  = ca;
            bus.cpu_wdata = cd;
            bus.dma_req   = dmaAct;
            bus.dma_we    = dmaWe;
            bus.dma_addr  = dmaA;
            bus.dma_wdata = dmaD;
            #1;
            if (bus.mem_en) begin
                rEns++;
                if (rEnFirst < 0) rEnFirst = c;
            end
            if (bus.mem_en && bus.mem_we) rWes++;
            if (cpuAct && !bus.stall) begin
                if (!cpuWr) check("cpu_rdata", bus.cpu_rdata, cExp);
                rCpuDone[k] = c;
                k++;
                cpuAct = 1'b0;
            end
            if (dmaAct && bus.dma_gnt) rGnt = c;
            if (dmaAct && bus.dma_done) begin
                if (!dmaWe) check("dma_rdata", bus.dma_rdata, dExp);
                rDmaDone = c;
                dmaAct = 1'b0;
            end
            c++;
        end
        check("timeout", {31'd0, (left > 0 || cpuAct || dmaAct)}, 32'd0);
        @(negedge clk);
        setIdle();
    endtask

    int          n, stray, stallHigh;
    bit          wr, dOn, dWe;
    logic [31:0] cb, da, dd;

    initial begin
        reset = 1'b1;
        setIdle();
        bus.cpu_rd = 1'b1;
        #12;
        check("rst_ctrl", {27'd0, bus.mem_en, bus.mem_we, bus.dma_gnt, bus.dma_done, bus.stall}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        @(negedge clk);
        setIdle();
        reset = 1'b0;

        // DMA preload then CPU load of 0xDEADBEEF
        runOps(0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        check("dma_wr_gnt", rGnt, 1);
        check("dma_wr_done", rDmaDone, 2);
        runOps(1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rd_done_cycle", rCpuDone[0], LAT + 2);
        check("rd_en_cycle", rEnFirst, 1);
        check("rd_en_count", rEns, 1);
        check("rd_hold_data", bus.cpu_rdata, 32'hDEAD_BEEF);

        // CPU store then readback
        runOps(1, 1'b1, 32'h10, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0);
        check("wr_done_cycle", rCpuDone[0], 2);
        check("wr_en_cycle", rEnFirst, 1);
        check("wr_en_count", rEns, 1);
        check("wr_we_count", rWes, 1);
        runOps(1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("wr_readback", bus.cpu_rdata, 32'h1234_5678);

        // simultaneous CPU load and DMA read: CPU first
        runOps(1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
        check("both_cpu_done", rCpuDone[0], LAT + 2);
        check("both_dma_gnt", rGnt, LAT + 4);
        check("both_dma_done", rDmaDone, 2 * LAT + 5);
        check("both_en_count", rEns, 2);

        // back-to-back CPU stores starve the DMA
        runOps(3, 1'b1, 32'h100, 32'hA5A5_0001, 1'b1, 1'b0, 32'h304, 32'h0);
        check("starve_wr_cpu0", rCpuDone[0], 2);
        check("starve_wr_cpu1", rCpuDone[1], 5);
        check("starve_wr_gnt", rGnt, expGnt(3));
        check("starve_wr_dma_done", rDmaDone, expGnt(3) + LAT + 1);
        check("starve_wr_cpu2", rCpuDone[2], expGnt(3) + LAT + 4);
        check("starve_wr_we_count", rWes, 3);

        // back-to-back CPU loads of those stores, DMA store waiting
        runOps(3, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 32'h308, 32'h7777_0308);
        check("starve_rd_cpu0", rCpuDone[0], LAT + 2);
        check("starve_rd_gnt", rGnt, expGnt(LAT + 3));
        check("starve_rd_dma_done", rDmaDone, expGnt(LAT + 3) + 1);
        check("starve_rd_cpu1", rCpuDone[1], expGnt(LAT + 3) + LAT + 4);

        // starvation history gone after the grant: CPU wins again
        runOps(1, 1'b0, 32'h104, 32'h0, 1'b1, 1'b0, 32'h308, 32'h0);
        check("clr_cpu_done", rCpuDone[0], LAT + 2);
        check("clr_dma_gnt", rGnt, LAT + 4);

        // reset in WAIT of a CPU load
        @(negedge clk);
        bus.cpu_rd    = 1'b1;
        bus.cpu_addr  = 32'h108;
        bus.cpu_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_ctrl", {27'd0, bus.mem_en, bus.mem_we, bus.dma_gnt, bus.dma_done, bus.stall}, 32'd0);
        check("rst_mid_cpu_rdata", bus.cpu_rdata, 32'd0);
        check("rst_mid_dma_rdata", bus.dma_rdata, 32'd0);
        check("rst_mid_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mid_mem_wdata", bus.mem_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        setIdle();
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (bus.mem_en || bus.dma_gnt || bus.dma_done) stray++;
        end
        check("rst_no_stray", stray, 0);
        runOps(1, 1'b0, 32'h108, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rst_after_rd", rCpuDone[0], LAT + 2);

        // CPU load flushed during WAIT still completes
        rEns = 0;
        stallHigh = 0;
        @(negedge clk);
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 32'h100;
        #1;
        if (bus.mem_en) rEns++;
        @(negedge clk);
        #1;
        if (bus.mem_en) rEns++;
        for (int c = 2; c < LAT + 6; c++) begin
            @(negedge clk);
            bus.cpu_rd = 1'b0;
            #1;
            if (bus.stall) stallHigh++;
            if (bus.mem_en) rEns++;
        end
        setIdle();
        check("flush_stall", stallHigh, 0);
        check("flush_en_count", rEns, 1);
        check("flush_rdata", bus.cpu_rdata, refRead(32'h100));
        runOps(1, 1'b1, 32'h0C0, 32'h0BAD_CAFE, 1'b0, 1'b0, 32'h0, 32'h0);
        check("flush_then_wr", rCpuDone[0], 2);

        // random mixes: CPU in the low region, DMA in the high region
        for (int it = 0; it < 24; it++) begin
            n   = $urandom_range(0, 3);
            wr  = 1'($urandom_range(0, 1));
            dOn = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            dWe = 1'($urandom_range(0, 1));
            cb  = 32'($urandom_range(0, 60)) << 2;
            da  = 32'h200 + (32'($urandom_range(0, 127)) << 2);
            dd  = $urandom;
            runOps(n, wr, cb, $urandom, dOn, dWe, da, dd);
            check("rnd_en_count", rEns, n + int'(dOn));
            check("rnd_we_count", rWes, (wr ? n : 0) + ((dOn && dWe) ? 1 : 0));
            if (n > 0) check("rnd_cpu_first", rCpuDone[0], wr ? 2 : LAT + 2);
            if (dOn) check("rnd_dma_span", rDmaDone - rGnt, dWe ? 1 : LAT + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
